// File: rtl/dmem_pkg.sv
// Shared access codes, MMIO offsets and helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  localparam logic [15:0] CON_TX_OFF = 16'h0000;
  localparam logic [15:0] STATUS_OFF = 16'h0004;
  localparam logic [15:0] CYCLE_OFF  = 16'h0008;

  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_CNT_LSB   = 4;
  localparam int unsigned STAT_CNT_W     = 4;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_e;

  function automatic acc_size_e decode_size(input logic [2:0] op);
    case (op)
      MEMOP_LB, MEMOP_LBU: return SZ_BYTE;
      MEMOP_LH, MEMOP_LHU: return SZ_HALF;
      MEMOP_LW:            return SZ_WORD;
      default:             return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_aligned(input acc_size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_HALF: return ~lane[0];
      SZ_WORD: return (lane == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_lanes(input acc_size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] extend8(input logic [7:0] b, input logic uns);
    return uns ? {24'h0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] extend16(input logic [15:0] h, input logic uns);
    return uns ? {16'h0, h} : {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/dmem_responder_con_fifo.sv
// Synchronous console FIFO; head entry is presented directly and reads as 0 when empty.
module con_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // a full FIFO still takes a push when the head leaves on the same edge
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    count = count_q;
    head  = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the pipeline core: byte-addressable RAM plus an MMIO window
// holding a console TX FIFO, a status register and a free-running cycle counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int unsigned CON_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemdatain,
  input  logic [2:0]  dmemop,
  input  logic        dmemwe,
  output logic [31:0] dmemdataout,
  output logic        misalign,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int unsigned RAM_WORDS = 2 ** (ADDR_WIDTH - 2);
  localparam int unsigned CON_CW    = $clog2(CON_DEPTH + 1);

  logic [31:0]           ram_q [RAM_WORDS];
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0]           rd_word;
  logic [31:0]           wr_word;
  logic [3:0]            wr_lanes;
  acc_size_e             acc_size;

  logic ram_hit, mmio_hit, aligned;
  logic ram_acc, ram_ok, ram_we;
  logic con_sel, stat_sel, cyc_sel;

  logic              con_push, con_pop;
  logic              con_full, con_empty;
  logic [CON_CW-1:0] con_count;
  logic [3:0]        stat_count;
  logic [31:0]       status_word;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  logic [31:0] dmemdataout_q, dmemdataout_d;
  logic [31:0] cycle_q, cycle_d;
  logic        misalign_q, misalign_d;
  logic        ovf_q, ovf_d;

  assign con_valid = ~con_empty;

  // address decode and access classification
  always_comb begin
    acc_size = decode_size(dmemop);
    word_idx = dmemaddr[ADDR_WIDTH-1:2];
    rd_word  = ram_q[word_idx];
    ram_hit  = (dmemaddr[31:ADDR_WIDTH] == '0);
    mmio_hit = (dmemaddr[31:16] == MMIO_BASE[31:16]);
    aligned  = is_aligned(acc_size, dmemaddr[1:0]);
    ram_acc  = ram_hit && (acc_size != SZ_NONE);
    ram_ok   = ram_acc && aligned;
    ram_we   = ram_ok && dmemwe;
    con_sel  = mmio_hit && (acc_size == SZ_WORD) && (dmemaddr[15:0] == CON_TX_OFF);
    stat_sel = mmio_hit && (acc_size == SZ_WORD) && (dmemaddr[15:0] == STATUS_OFF);
    cyc_sel  = mmio_hit && (acc_size == SZ_WORD) && (dmemaddr[15:0] == CYCLE_OFF);
  end

  // store lane steering and load extraction
  always_comb begin
    wr_lanes = store_lanes(acc_size, dmemaddr[1:0]);
    case (acc_size)
      SZ_BYTE: wr_word = {4{dmemdatain[7:0]}};
      SZ_HALF: wr_word = {2{dmemdatain[15:0]}};
      default: wr_word = dmemdatain;
    endcase

    byte_sel = rd_word[{dmemaddr[1:0], 3'b000} +: 8];
    half_sel = rd_word[{dmemaddr[1], 4'b0000} +: 16];
    case (acc_size)
      SZ_BYTE: load_val = extend8(byte_sel, dmemop[2]);
      SZ_HALF: load_val = extend16(half_sel, dmemop[2]);
      SZ_WORD: load_val = rd_word;
      default: load_val = '0;
    endcase
  end

  always_comb begin
    stat_count  = (int'(con_count) > 15) ? 4'hF : 4'(con_count);
    status_word = '0;
    status_word[STAT_FULL_BIT]                = con_full;
    status_word[STAT_EMPTY_BIT]               = con_empty;
    status_word[STAT_OVF_BIT]                 = ovf_q;
    status_word[STAT_CNT_LSB +: STAT_CNT_W]   = stat_count;
  end

  always_comb begin
    dmemdataout_d = '0;
    if (!dmemwe) begin
      if (ram_ok) begin
        dmemdataout_d = load_val;
      end else if (stat_sel) begin
        dmemdataout_d = status_word;
      end else if (cyc_sel) begin
        dmemdataout_d = cycle_q;
      end
    end

    misalign_d = misalign_q | (ram_acc & ~aligned);

    con_pop  = con_valid & con_ready;
    con_push = dmemwe & con_sel;

    ovf_d = ovf_q;
    if (dmemwe && stat_sel) begin
      ovf_d = 1'b0;
    end else if (con_push && con_full && !con_pop) begin
      ovf_d = 1'b1;
    end

    cycle_d = (dmemwe && cyc_sel) ? dmemdatain : cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      dmemdataout_q <= '0;
      misalign_q    <= 1'b0;
      ovf_q         <= 1'b0;
      cycle_q       <= '0;
    end else begin
      dmemdataout_q <= dmemdataout_d;
      misalign_q    <= misalign_d;
      ovf_q         <= ovf_d;
      cycle_q       <= cycle_d;
    end
  end

  // RAM contents survive clr; only the write is blocked in a reset cycle
  always_ff @(posedge clk) begin
    if (!clr && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_lanes[i]) begin
          ram_q[word_idx][i*8 +: 8] <= wr_word[i*8 +: 8];
        end
      end
    end
  end

  con_fifo #(
    .DEPTH (CON_DEPTH),
    .WIDTH (8)
  ) u_con_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (con_push),
    .pop   (con_pop),
    .din   (dmemdatain[7:0]),
    .full  (con_full),
    .empty (con_empty),
    .count (con_count),
    .head  (con_data)
  );

  assign dmemdataout = dmemdataout_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand sequences and random traffic
// checked against a byte-level reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] dmemaddr;
  logic [31:0] dmemdatain;
  logic [2:0]  dmemop;
  logic        dmemwe;
  logic [31:0] dmemdataout;
  logic        misalign;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk         (clk),
    .clr         (clr),
    .dmemaddr    (dmemaddr),
    .dmemdatain  (dmemdatain),
    .dmemop      (dmemop),
    .dmemwe      (dmemwe),
    .dmemdataout (dmemdataout),
    .misalign    (misalign),
    .con_data    (con_data),
    .con_valid   (con_valid),
    .con_ready   (con_ready)
  );

  localparam int          RAM_BYTES = 32768;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] CON_A     = 32'hFFFF_0000;
  localparam logic [31:0] STAT_A    = 32'hFFFF_0004;
  localparam logic [31:0] CYC_A     = 32'hFFFF_0008;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  logic [7:0]  ram_m [RAM_BYTES];
  logic [7:0]  fifo_m [$];
  bit          m_ovf;
  bit          m_mis;
  logic [31:0] m_cyc;
  logic [31:0] m_dout;
  bit          m_dout_chk;

  typedef struct {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] din;
    logic        chk;
    logic [31:0] exp_dout;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Advance the model by one rising edge using only pre-edge state.
  function automatic void model_edge(input logic c, input logic w, input logic [2:0] op,
                                     input logic [31:0] a, input logic [31:0] d, input logic r);
    int          n;
    int          cnt;
    bit          pop;
    bit          push;
    bit          wr_cyc;
    logic [31:0] v;
    pop        = r && (fifo_m.size() != 0);
    push       = 0;
    wr_cyc     = 0;
    m_dout_chk = !w || c;
    if (c) begin
      m_dout = 0;
      m_mis  = 0;
      m_ovf  = 0;
      m_cyc  = 0;
      fifo_m.delete();
      return;
    end
    m_dout = 0;
    case (op)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    if (a < RAM_BYTES && n != 0) begin
      if (a % n != 0) m_mis = 1;
      else if (w) begin
        for (int i = 0; i < n; i++) ram_m[a + i] = d[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ram_m[a + i];
        if (op == 3'd0 && v[7])  v[31:8]  = '1;
        if (op == 3'd1 && v[15]) v[31:16] = '1;
        m_dout = v;
      end
    end else if (a[31:16] == 16'hFFFF && op == 3'd2) begin
      case (a[15:0])
        16'h0000: if (w) begin
          if (fifo_m.size() < DEPTH || pop) push = 1;
          else m_ovf = 1;
        end
        16'h0004: if (w) m_ovf = 0;
        else begin
          cnt    = (fifo_m.size() > 15) ? 15 : fifo_m.size();
          m_dout = {24'h0, 4'(cnt), 1'b0, m_ovf, fifo_m.size() == 0, fifo_m.size() == DEPTH};
        end
        16'h0008: if (w) wr_cyc = 1;
        else m_dout = m_cyc;
        default: ;
      endcase
    end
    m_cyc = wr_cyc ? d : m_cyc + 1;
    if (pop) void'(fifo_m.pop_front());
    if (push) fifo_m.push_back(d[7:0]);
  endfunction

  task automatic step(input logic c, input logic w, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] d, input logic r);
    @(negedge clk);
    clr        = c;
    dmemwe     = w;
    dmemop     = op;
    dmemaddr   = a;
    dmemdatain = d;
    con_ready  = r;
    model_edge(c, w, op, a, d, r);
    @(posedge clk);
    #1;
    if (m_dout_chk) check("model_dout", dmemdataout, m_dout);
    check("model_misalign", {31'b0, misalign}, {31'b0, m_mis});
    check("model_con_valid", {31'b0, con_valid}, {31'b0, fifo_m.size() != 0});
    check("model_con_data", {24'b0, con_data}, {24'b0, (fifo_m.size() != 0) ? fifo_m[0] : 8'h00});
  endtask

  function automatic void add_vec(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] din, input logic chk,
                                  input logic [31:0] exp_dout, input logic exp_mis);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.din = din;
    v.chk = chk; v.exp_dout = exp_dout; v.exp_mis = exp_mis;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] offs [5];
    logic [31:0] a;
    logic [2:0]  op;
    logic        w;
    logic        r;
    logic        c;
    int          sel;

    offs = '{16'h0000, 16'h0004, 16'h0008, 16'h0002, 16'h000C};
    clr = 1'b1; dmemwe = 1'b0; dmemop = 3'd2; dmemaddr = 0; dmemdatain = 0; con_ready = 1'b0;
    m_ovf = 0; m_mis = 0; m_cyc = 0; m_dout = 0; m_dout_chk = 0;

    // reset
    step(1, 0, 3'd2, 0, 0, 0);
    step(1, 0, 3'd2, 0, 0, 0);
    check("reset_dout", dmemdataout, 32'h0);
    check("reset_misalign", {31'b0, misalign}, 32'h0);
    check("reset_con_valid", {31'b0, con_valid}, 32'h0);
    check("reset_con_data", {24'b0, con_data}, 32'h0);

    // directed table: we, op, addr, din, chk, expected dout, expected misalign
    add_vec(1, 3'd2, 32'h100, 32'h8081_F2F3, 0, 0, 0);
    add_vec(0, 3'd0, 32'h100, 0, 1, 32'hFFFF_FFF3, 0);
    add_vec(0, 3'd4, 32'h100, 0, 1, 32'h0000_00F3, 0);
    add_vec(0, 3'd1, 32'h100, 0, 1, 32'hFFFF_F2F3, 0);
    add_vec(0, 3'd5, 32'h100, 0, 1, 32'h0000_F2F3, 0);
    add_vec(0, 3'd2, 32'h100, 0, 1, 32'h8081_F2F3, 0);
    add_vec(0, 3'd0, 32'h103, 0, 1, 32'hFFFF_FF80, 0);
    add_vec(1, 3'd2, 32'h200, 32'h1122_3344, 0, 0, 0);
    add_vec(1, 3'd0, 32'h201, 32'h0000_00AA, 0, 0, 0);
    add_vec(0, 3'd2, 32'h200, 0, 1, 32'h1122_AA44, 0);
    add_vec(1, 3'd1, 32'h202, 32'h0000_5566, 0, 0, 0);
    add_vec(0, 3'd2, 32'h200, 0, 1, 32'h5566_AA44, 0);
    add_vec(0, 3'd2, 32'h0001_0000, 0, 1, 32'h0, 0);
    add_vec(0, 3'd3, 32'h100, 0, 1, 32'h0, 0);
    add_vec(1, 3'd6, 32'h200, 32'hFFFF_FFFF, 0, 0, 0);
    add_vec(0, 3'd2, 32'h200, 0, 1, 32'h5566_AA44, 0);
    add_vec(1, 3'd2, 32'h102, 32'hDEAD_BEEF, 0, 0, 1);
    add_vec(0, 3'd2, 32'h100, 0, 1, 32'h8081_F2F3, 1);
    add_vec(0, 3'd1, 32'h101, 0, 1, 32'h0, 1);
    add_vec(1, 3'd2, CYC_A, 32'hFFFF_FFFE, 0, 0, 1);
    add_vec(0, 3'd2, CYC_A, 0, 1, 32'hFFFF_FFFE, 1);
    add_vec(0, 3'd2, CYC_A, 0, 1, 32'hFFFF_FFFF, 1);
    add_vec(0, 3'd2, CYC_A, 0, 1, 32'h0000_0000, 1);
    add_vec(0, 3'd1, CYC_A, 0, 1, 32'h0, 1);

    foreach (vecs[i]) begin
      step(0, vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].din, 0);
      if (vecs[i].chk) check($sformatf("vec%0d_dout", i), dmemdataout, vecs[i].exp_dout);
      check($sformatf("vec%0d_misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
    end

    step(1, 0, 3'd2, 0, 0, 0);
    check("clr_clears_misalign", {31'b0, misalign}, 32'h0);

    // console FIFO: overfill, status, drain, push-while-full-and-popping
    for (int i = 0; i < 5; i++) step(0, 1, 3'd2, CON_A, 32'h41 + i, 0);
    step(0, 0, 3'd2, STAT_A, 0, 0);
    check("status_full_ovf", dmemdataout, 32'h0000_0045);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_byte%0d", i), {24'b0, con_data}, 32'h41 + i);
      step(0, 0, 3'd2, 32'h100, 0, 1);
    end
    check("drained_valid", {31'b0, con_valid}, 32'h0);
    step(0, 1, 3'd2, STAT_A, 0, 0);
    step(0, 0, 3'd2, STAT_A, 0, 0);
    check("status_ovf_cleared", dmemdataout, 32'h0000_0002);
    for (int i = 0; i < 4; i++) step(0, 1, 3'd2, CON_A, 32'h50 + i, 0);
    step(0, 1, 3'd2, CON_A, 32'h54, 1);
    step(0, 0, 3'd2, STAT_A, 0, 0);
    check("status_push_on_pop", dmemdataout, 32'h0000_0041);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("refill_byte%0d", i), {24'b0, con_data}, 32'h51 + i);
      step(0, 0, 3'd2, 32'h100, 0, 1);
    end

    // clr in the middle of stores and pushes
    step(0, 1, 3'd2, 32'h304, 32'h0BAD_F00D, 0);
    step(0, 1, 3'd2, CON_A, 32'h61, 0);
    step(0, 1, 3'd2, 32'h300, 32'hCAFE_BABE, 0);
    step(1, 1, 3'd2, 32'h304, 32'h1234_5678, 0);
    check("clr_dout", dmemdataout, 32'h0);
    check("clr_fifo_empty", {31'b0, con_valid}, 32'h0);
    step(0, 0, 3'd2, 32'h304, 0, 0);
    check("clr_store_blocked", dmemdataout, 32'h0BAD_F00D);
    step(0, 0, 3'd2, 32'h300, 0, 0);
    check("ram_retained", dmemdataout, 32'hCAFE_BABE);
    step(0, 1, 3'd2, CON_A, 32'h62, 0);
    step(1, 1, 3'd2, CON_A, 32'h63, 0);
    check("clr_push_blocked", {31'b0, con_valid}, 32'h0);
    step(0, 0, 3'd2, CYC_A, 0, 0);
    check("cycle_after_clr0", dmemdataout, 32'h0);
    step(0, 0, 3'd2, CYC_A, 0, 0);
    check("cycle_after_clr1", dmemdataout, 32'h1);

    // random traffic against the model
    for (int a4 = 32'h400; a4 < 32'h500; a4 += 4) step(0, 1, 3'd2, a4, $urandom, 0);
    for (int k = 0; k < 2000; k++) begin
      sel = int'($urandom_range(99));
      w   = 1'($urandom_range(1));
      op  = 3'($urandom_range(7));
      r   = 1'($urandom_range(1));
      c   = ($urandom_range(199) == 0);
      if (sel < 60) begin
        a = 32'h400 + $urandom_range(255);
      end else if (sel < 90) begin
        a = {16'hFFFF, offs[$urandom_range(4)]};
        if ($urandom_range(3) != 0) op = 3'd2;
      end else begin
        a = 32'h0002_0000 | $urandom_range(65535);
      end
      step(c, w, op, a, $urandom, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
